// File: rtl/composer_pixel_sequencer.sv
// composer_pixel_sequencer
// Raster walker for the composer path. For every active pixel it issues a
// single fetch to the background and sprite layers. It collects both replies
// in any order, keys the sprite against TRANSPARENT and hands the composed
// pixel to the video FIFO through the wrreq/wrfull handshake.
module composer_pixel_sequencer #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter logic [23:0] TRANSPARENT = 24'hFF00FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        fetch_req,
    output logic [9:0]  fetch_x,
    output logic [9:0]  fetch_y,
    input  logic        bg_valid,
    input  logic [23:0] bg_pixel,
    input  logic        spr_valid,
    input  logic [23:0] spr_pixel,
    input  logic        wrfull,
    output logic        wrreq,
    output logic [23:0] pixel_out,
    output logic        new_frame_test,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    logic [1:0]  state_q,   state_d;
    logic [9:0]  x_q,       x_d;
    logic [9:0]  y_q,       y_d;
    logic        bg_got_q,  bg_got_d;
    logic        spr_got_q, spr_got_d;
    logic [23:0] bg_pix_q,  bg_pix_d;
    logic [23:0] spr_pix_q, spr_pix_d;
    logic [23:0] pixel_q,   pixel_d;
    logic [15:0] frame_q,   frame_d;

    logic        bg_now;
    logic        spr_now;
    logic [23:0] bg_sel;
    logic [23:0] spr_sel;
    logic        write_fire;

    // A pulse arriving this cycle counts as already held, so the pixel can
    // be composed without waiting for the latch to settle into the flag.
    always_comb begin
        bg_now     = bg_got_q | bg_valid;
        spr_now    = spr_got_q | spr_valid;
        bg_sel     = bg_valid  ? bg_pixel  : bg_pix_q;
        spr_sel    = spr_valid ? spr_pixel : spr_pix_q;
        write_fire = (state_q == ST_WRITE) && !wrfull;
    end

    // Next-state logic: raster position, response capture, composition.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        bg_got_d  = bg_got_q;
        spr_got_d = spr_got_q;
        bg_pix_d  = bg_pix_q;
        spr_pix_d = spr_pix_q;
        pixel_d   = pixel_q;
        frame_d   = frame_q;

        case (state_q)
            ST_IDLE: begin
                x_d = '0;
                y_d = '0;
                if (enable) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                bg_got_d  = 1'b0;
                spr_got_d = 1'b0;
                state_d   = ST_WAIT;
            end

            ST_WAIT: begin
                if (bg_valid) begin
                    bg_got_d = 1'b1;
                    bg_pix_d = bg_pixel;
                end
                if (spr_valid) begin
                    spr_got_d = 1'b1;
                    spr_pix_d = spr_pixel;
                end
                if (bg_now && spr_now) begin
                    pixel_d = (spr_sel == TRANSPARENT) ? bg_sel : spr_sel;
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                if (write_fire) begin
                    if (x_q != X_LAST) begin
                        x_d     = x_q + 10'd1;
                        state_d = ST_FETCH;
                    end else if (y_q != Y_LAST) begin
                        x_d     = '0;
                        y_d     = y_q + 10'd1;
                        state_d = ST_FETCH;
                    end else begin
                        x_d     = '0;
                        y_d     = '0;
                        frame_d = frame_q + 16'd1;
                        state_d = enable ? ST_FETCH : ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any pixel in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            bg_got_q  <= 1'b0;
            spr_got_q <= 1'b0;
            bg_pix_q  <= '0;
            spr_pix_q <= '0;
            pixel_q   <= '0;
            frame_q   <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bg_got_q  <= bg_got_d;
            spr_got_q <= spr_got_d;
            bg_pix_q  <= bg_pix_d;
            spr_pix_q <= spr_pix_d;
            pixel_q   <= pixel_d;
            frame_q   <= frame_d;
        end
    end

    // Output decode; wrreq follows wrfull combinationally.
    always_comb begin
        fetch_req      = (state_q == ST_FETCH);
        fetch_x        = x_q;
        fetch_y        = y_q;
        wrreq          = write_fire;
        pixel_out      = pixel_q;
        new_frame_test = write_fire && (x_q == '0) && (y_q == '0);
        frame_count    = frame_q;
        busy           = (state_q != ST_IDLE);
    end

endmodule

// File: doc/composer_pixel_sequencer.md
# composer_pixel_sequencer

Raster sequencer for the VPU composer path. It walks the active frame pixel by pixel and issues one fetch per pixel to the background layer and to the sprite layer. It merges the two responses by transparency and pushes the result into the downstream video FIFO through a wrreq/wrfull handshake. It sits between the layer fetch units (background loader side) and the composer conduit (pixel_out / wrreq / wrfull / new_frame_test).

## Interface
Parameters:
- H_ACTIVE, 640, pixels per line (≥2)
- V_ACTIVE, 480, lines per frame (≥2)
- TRANSPARENT, 24'hFF00FF, sprite colour key meaning "no sprite"

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  level; run frames while high
- fetch_req  out  1  one-cycle pulse; requests pixel at (fetch_x, fetch_y) from both layers
- fetch_x  out  10  column of current pixel
- fetch_y  out  10  line of current pixel
- bg_valid  in  1  one-cycle pulse; bg_pixel valid
- bg_pixel  in  24  background RGB888
- spr_valid  in  1  one-cycle pulse; spr_pixel valid
- spr_pixel  in  24  sprite RGB888, TRANSPARENT = none
- wrfull  in  1  downstream FIFO full
- wrreq  out  1  FIFO write strobe
- pixel_out  out  24  composed pixel, valid while wrreq high
- new_frame_test  out  1  high with wrreq for pixel (0,0) only
- frame_count  out  16  completed frames, wraps 16'hFFFF→0
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, FETCH, WAIT, WRITE.
- IDLE: x=0, y=0. Go to FETCH when enable=1.
- FETCH: fetch_req=1 for exactly one cycle. fetch_x/fetch_y hold x/y (registered; stable from FETCH until the pixel is written). Clear the bg_got and spr_got flags. Go to WAIT.
- WAIT:
  - A bg_valid pulse latches bg_pixel and sets bg_got.
  - A spr_valid pulse latches spr_pixel and sets spr_got.
  - Both pulses may arrive in the same cycle or in either order, with unbounded latency.
  - Once both flags are set (counting pulses arriving this cycle), register the composed pixel into pixel_out and go to WRITE next cycle.
- Valids seen outside WAIT (IDLE, FETCH, WRITE) are ignored. Layers respond no earlier than the cycle after fetch_req.
- Compose: pixel_out = (spr_pixel == TRANSPARENT) ? bg_pixel : spr_pixel. The comparison is a full 24-bit equality.
- WRITE: wrreq = (state==WRITE) && !wrfull (combinational from wrfull). pixel_out holds while wrfull=1. On the cycle wrreq=1:
  - x<H_ACTIVE-1: x+1, go to FETCH.
  - x==H_ACTIVE-1, y<V_ACTIVE-1: x=0, y+1, go to FETCH.
  - Last pixel of the frame: x=0, y=0, frame_count+1. Go to FETCH if enable=1, else IDLE.
- enable is only sampled in IDLE and at the last-pixel write. Deasserting it mid-frame completes the frame.
- new_frame_test = wrreq && x==0 && y==0.
- busy = state != IDLE.

## Timing
- Reset values: state IDLE, fetch_req 0, fetch_x 0, fetch_y 0, pixel_out 0, wrreq 0, new_frame_test 0, frame_count 0, busy 0, flags cleared.
- Reset asserted mid-pixel: the pending fetch is abandoned and late valids are ignored (state is IDLE). After release, the next frame restarts at (0,0).
- enable rises at cycle n (seen in IDLE): fetch_req at n+1.
- Minimum pixel period is 3 cycles (FETCH, WAIT, WRITE), reached when both valids arrive at FETCH+1 and wrfull=0.
- The last valid arrives at cycle k: pixel_out updates at k+1 and wrreq is eligible at k+1.
- After a write at cycle w: the next fetch_req is at w+1, and fetch_x/fetch_y update at w+1.
- wrreq never asserts while wrfull=1. Exactly one wrreq per pixel, H_ACTIVE*V_ACTIVE per frame.

## Test plan
- Reset: hold reset with enable=1 and random inputs → every output 0. After release: fetch_req 2 cycles later at (0,0).
- Transparent sprite: bg 24'h112233 and spr 24'hFF00FF at req+1 → pixel_out=24'h112233, one wrreq cycle, new_frame_test=1, next fetch_req at (1,0).
- Opaque sprite: bg 24'h112233, spr 24'h0000FF → pixel_out=24'h0000FF. Out-of-order responses (spr at req+1, bg at req+6) → wrreq exactly one cycle after bg_valid. A duplicate spr_valid while in WRITE has no effect.
- Backpressure: wrfull=1 for 10 cycles in WRITE → wrreq 0 and pixel_out stable. wrfull→0 gives exactly one wrreq.
- Wrap with H_ACTIVE=4, V_ACTIVE=2 and immediate responses → 8 writes, fetch sequence (0,0)…(3,0),(0,1)…(3,1). Then frame_count=1 and the 9th write carries new_frame_test.
- enable dropped at pixel 3 of the small frame → frame completes to 8 writes, then IDLE, busy=0, frame_count=1. Reset asserted while in WAIT → IDLE, outputs 0, and a late bg_valid is ignored.
